// File: rtl/gpu_prefetch_queue.sv
// Instruction prefetch queue for the GPU/DSP RISC core.
// Fetches longwords from program RAM and hands 16-bit words to decode.
module gpu_prefetch_queue #(
   parameter int DEPTH = 6
) (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic [22:0] pc,
   input  logic        flush,
   output logic        progreq,
   output logic [21:0] progaddr,
   input  logic        progack,
   input  logic [31:0] progdata,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic        instr_take,
   output logic [2:0]  qs_n
);

   typedef enum logic {IDLE, REQ} state_t;

   localparam logic [2:0] LAST = 3'(DEPTH - 1);
   localparam logic [3:0] CAP  = 4'(DEPTH);

   state_t      state_q, state_d;
   logic [2:0]  rd_q, rd_d;
   logic [2:0]  wr_q, wr_d;
   logic [2:0]  count_q, count_d;
   logic [15:0] mem_q [DEPTH];
   logic [15:0] mem_d [DEPTH];

   logic        accept;
   logic        take;
   logic [3:0]  n_in;
   logic [3:0]  count_sum;
   logic        space_ok;

   function automatic logic [2:0] nxt(input logic [2:0] p);
      return (p == LAST) ? 3'd0 : p + 3'd1;
   endfunction

   // Accepted words, consumed words and room for one more longword
   always_comb begin
      accept    = progack & ~flush & (state_q == REQ);
      take      = instr_take & (count_q != 3'd0);
      n_in      = accept ? (pc[0] ? 4'd1 : 4'd2) : 4'd0;
      count_sum = {1'b0, count_q} + n_in - {3'b000, take};
      space_ok  = (count_sum + 4'd2) <= CAP;
   end

   // Circular buffer writes, pointer moves and occupancy update
   always_comb begin
      mem_d   = mem_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      if (flush) begin
         count_d = 3'd0;
         rd_d    = wr_q;
      end else begin
         if (accept) begin
            if (pc[0]) begin
               mem_d[wr_q] = progdata[15:0];
               wr_d        = nxt(wr_q);
            end else begin
               mem_d[wr_q]      = progdata[31:16];
               mem_d[nxt(wr_q)] = progdata[15:0];
               wr_d             = nxt(nxt(wr_q));
            end
         end
         if (take) begin
            rd_d = nxt(rd_q);
         end
         count_d = count_sum[2:0];
      end
   end

   // Request FSM: issue only when a whole longword is guaranteed to fit
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (!flush && space_ok) begin
               state_d = REQ;
            end
         end
         REQ: begin
            if (flush) begin
               state_d = IDLE;
            end else if (progack) begin
               state_d = space_ok ? REQ : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control state registers
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q <= IDLE;
         rd_q    <= 3'd0;
         wr_q    <= 3'd0;
         count_q <= 3'd0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
      end
   end

   // Word storage; contents are masked by count so no reset is needed
   always_ff @(posedge sys_clk) begin
      mem_q <= mem_d;
   end

   // Registered request and head-of-queue outputs
   always_comb begin
      progreq     = (state_q == REQ);
      progaddr    = pc[22:1];
      instr_valid = (count_q != 3'd0);
      instr       = instr_valid ? mem_q[rd_q] : 16'h0000;
      qs_n        = ~(count_q - 3'd1);
   end

endmodule

// File: tb/tb_gpu_prefetch_queue.sv
// Self-checking bench for gpu_prefetch_queue.
// Directed steps followed by a randomized phase against a word-queue model.
module tb_gpu_prefetch_queue;

   localparam int DEPTH = 6;

   logic        sys_clk = 1'b0;
   logic        reset = 1'b1;
   logic [22:0] pc = 23'h0;
   logic        flush = 1'b0;
   logic        progreq;
   logic [21:0] progaddr;
   logic        progack = 1'b0;
   logic [31:0] progdata = 32'h0;
   logic [15:0] instr;
   logic        instr_valid;
   logic        instr_take = 1'b0;
   logic [2:0]  qs_n;

   int checks = 0;
   int errors = 0;

   logic [15:0] q[$];
   logic        exp_req = 1'b0;
   logic [22:0] jump_target = 23'h0;
   logic        did_acc;
   logic        did_flush;

   gpu_prefetch_queue #(.DEPTH(DEPTH)) dut (
      .sys_clk     (sys_clk),
      .reset       (reset),
      .pc          (pc),
      .flush       (flush),
      .progreq     (progreq),
      .progaddr    (progaddr),
      .progack     (progack),
      .progdata    (progdata),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_take  (instr_take),
      .qs_n        (qs_n)
   );

   always #5 sys_clk = ~sys_clk;

   // Spec-level model: a FIFO of words; a request is outstanding exactly
   // when the queue has room for a full longword and no jump/reset occurred.
   task automatic model_edge();
      did_acc   = 1'b0;
      did_flush = 1'b0;
      if (reset) begin
         q.delete();
         exp_req = 1'b0;
         return;
      end
      if (flush) begin
         q.delete();
         exp_req   = 1'b0;
         did_flush = 1'b1;
         return;
      end
      if (instr_take && q.size() > 0) void'(q.pop_front());
      if (progack && exp_req) begin
         did_acc = 1'b1;
         if (!pc[0]) q.push_back(progdata[31:16]);
         q.push_back(progdata[15:0]);
      end
      exp_req = (q.size() + 2 <= DEPTH);
   endtask

   task automatic chk1(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [15:0] ei;
      logic [2:0]  eq;
      ei = (q.size() > 0) ? q[0] : 16'h0000;
      eq = 3'(8 - q.size());
      chk1({tag, ".progreq"}, 32'(progreq), 32'(exp_req));
      chk1({tag, ".progaddr"}, 32'(progaddr), 32'(pc[22:1]));
      chk1({tag, ".valid"}, 32'(instr_valid), 32'(q.size() > 0));
      chk1({tag, ".instr"}, 32'(instr), 32'(ei));
      chk1({tag, ".qs_n"}, 32'(qs_n), 32'(eq));
   endtask

   task automatic tick(input string tag);
      @(posedge sys_clk);
      model_edge();
      #1;
      if (did_flush) pc = jump_target;
      else if (did_acc) pc = (pc | 23'h1) + 23'h1;
      progack    = 1'b0;
      flush      = 1'b0;
      instr_take = 1'b0;
      check_all(tag);
   endtask

   initial begin
      int acks;
      #1;
      // Reset
      reset = 1'b1;
      pc    = 23'h7F8004;
      for (int i = 0; i < 3; i++) tick("reset");
      chk1("rst.qs_n", 32'(qs_n), 32'h0);
      reset = 1'b0;
      tick("release");
      chk1("rel.progreq", 32'(progreq), 32'h1);
      chk1("rel.progaddr", 32'(progaddr), 32'h3FC002);

      // Cold fill
      progack  = 1'b1;
      progdata = 32'hA1B2C3D4;
      tick("fill");
      chk1("fill.instr", 32'(instr), 32'hA1B2);
      chk1("fill.qs_n", 32'(qs_n), 32'h6);
      instr_take = 1'b1;
      tick("fill_take");
      chk1("take.instr", 32'(instr), 32'hC3D4);
      chk1("take.qs_n", 32'(qs_n), 32'h7);

      // Odd jump
      flush       = 1'b1;
      jump_target = 23'h000101;
      tick("jump");
      chk1("jump.progreq", 32'(progreq), 32'h0);
      tick("jump_rereq");
      chk1("jump.rereq", 32'(progreq), 32'h1);
      progack  = 1'b1;
      progdata = 32'h11112222;
      tick("odd_ack");
      chk1("odd.instr", 32'(instr), 32'h2222);
      chk1("odd.qs_n", 32'(qs_n), 32'h7);
      instr_take = 1'b1;
      tick("odd_drain");
      chk1("odd.empty", 32'(instr_valid), 32'h0);

      // Full stall
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         if (progreq) begin
            progack  = 1'b1;
            progdata = $urandom;
            acks++;
         end
         tick("stall");
      end
      chk1("stall.acks", 32'(acks), 32'd3);
      chk1("stall.qs_n", 32'(qs_n), 32'h2);
      instr_take = 1'b1;
      tick("stall_take1");
      chk1("stall.req1", 32'(progreq), 32'h0);
      instr_take = 1'b1;
      tick("stall_take2");
      chk1("stall.req2", 32'(progreq), 32'h1);

      // Flush racing ack
      progack     = 1'b1;
      progdata    = 32'hDEADBEEF;
      flush       = 1'b1;
      jump_target = 23'h000200;
      tick("race");
      chk1("race.qs_n", 32'(qs_n), 32'h0);
      chk1("race.progreq", 32'(progreq), 32'h0);
      tick("race_rereq");
      chk1("race.rereq", 32'(progreq), 32'h1);

      // Simultaneous accept and take, with a write wrapping 5->0
      progack  = 1'b1;
      progdata = 32'h01020304;
      tick("sim_fill");
      progack    = 1'b1;
      progdata   = 32'h05060708;
      instr_take = 1'b1;
      tick("sim_both");
      chk1("sim.qs_n", 32'(qs_n), 32'h5);
      chk1("sim.instr", 32'(instr), 32'h0304);
      for (int i = 0; i < 3; i++) begin
         instr_take = 1'b1;
         tick("sim_drain");
      end
      chk1("sim.empty", 32'(instr_valid), 32'h0);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         instr_take = ($urandom_range(0, 1) == 1);
         if (progreq && $urandom_range(0, 9) < 7) begin
            progack  = 1'b1;
            progdata = $urandom;
         end
         if ($urandom_range(0, 99) < 3) begin
            flush       = 1'b1;
            jump_target = 23'($urandom);
         end
         reset = ($urandom_range(0, 199) == 0);
         tick("rand");
         reset = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
